// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// The auxiliary FIFO entry pairs a destination register with its result data.
package wb_port_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } aux_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the write-back/auxiliary producers and the arbiter.
// The slave modport is the arbiter's view; master is the producers' view.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              pipe_wb_en;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              aux_valid;
  logic              aux_ready;
  logic [ADDR_W-1:0] aux_rd;
  logic [DATA_W-1:0] aux_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic              pipe_stall;
  logic [ADDR_W-1:0] hz_rn;
  logic              hz_busy;

  modport slave (
    input  pipe_wb_en, pipe_rd, pipe_data,
    input  aux_valid, aux_rd, aux_data,
    input  hz_rn,
    output aux_ready, rf_we, rf_wa, rf_wd, pipe_stall, hz_busy
  );

  modport master (
    output pipe_wb_en, pipe_rd, pipe_data,
    output aux_valid, aux_rd, aux_data,
    output hz_rn,
    input  aux_ready, rf_we, rf_wa, rf_wd, pipe_stall, hz_busy
  );

endinterface

// File: rtl/wb_aux_fifo.sv
// Small circular buffer for auxiliary results awaiting the write port.
// Exposes per-slot valid flags and destinations so the owner can check hazards.
module wb_aux_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter type entry_t = aux_entry_t,
  parameter int  ADDR_W  = DEF_ADDR_W,
  parameter int  DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  entry_t            push_entry,
  input  logic              pop,
  output entry_t            head,
  output logic              full,
  output logic              empty,
  output logic [DEPTH-1:0]  entry_valid,
  output logic [ADDR_W-1:0] entry_rd [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_entry;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the fill count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] offset;
    assign offset         = PTR_W'(i) - rptr;
    assign entry_valid[i] = (CNT_W'(offset) < count);
    assign entry_rd[i]    = mem[i].rd;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline has priority, auxiliary results
// queue in a FIFO and drain on idle cycles or via a one-cycle forced stall.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            push_entry;
  entry_t            head;
  logic              full;
  logic              empty;
  logic [DEPTH-1:0]  entry_valid;
  logic [ADDR_W-1:0] entry_rd [DEPTH];

  arb_state_t        state;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_inc;
  logic              push;
  logic              pop;
  logic              pipe_grant;
  logic              hz_hit;

  assign push_entry = '{rd: bus.aux_rd, data: bus.aux_data};

  wb_aux_fifo #(
    .entry_t (entry_t),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // Readiness ignores a same-cycle pop, so a full FIFO never pushes while draining.
  always_comb begin
    bus.aux_ready = !rst && !full;
    push          = bus.aux_valid && !rst && !full;
    pop           = 1'b0;
    pipe_grant    = 1'b0;
    if (!rst) begin
      if (state == FORCE) begin
        pop = !empty;
      end else if (bus.pipe_wb_en) begin
        pipe_grant = 1'b1;
      end else begin
        pop = !empty;
      end
    end
    bus.rf_we      = pipe_grant || pop;
    bus.rf_wa      = '0;
    bus.rf_wd      = '0;
    if (pipe_grant) begin
      bus.rf_wa = bus.pipe_rd;
      bus.rf_wd = bus.pipe_data;
    end else if (pop) begin
      bus.rf_wa = head.rd;
      bus.rf_wd = head.data;
    end
    bus.pipe_stall = !rst && (state == FORCE);
  end

  // The head being popped this cycle is still live, so it still reports busy.
  always_comb begin
    hz_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_rd[i] == bus.hz_rn)) begin
        hz_hit = 1'b1;
      end
    end
    bus.hz_busy = hz_hit && !rst;
  end

  assign starve_inc = (starve_cnt == CNT_W'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (bus.pipe_wb_en && !empty) begin
            starve_cnt <= starve_inc;
            if (starve_inc == CNT_W'(STARVE_LIMIT)) begin
              state <= FORCE;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        FORCE: begin
          starve_cnt <= '0;
          state      <= NORMAL;
        end
        default: begin
          starve_cnt <= '0;
          state      <= NORMAL;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the pipeline write-back stage and a long-latency auxiliary unit (multi-cycle multiplier / late load return). The pipeline has priority. Auxiliary results are buffered in a small FIFO and drained on idle write-back cycles. A starvation counter can freeze the pipeline for one cycle to force an auxiliary drain. A scoreboard query port reports registers with buffered pending writes, for hazard detection.

Parameters:
DATA_W, 32, register data width
ADDR_W, 4, register address width (R0-R15)
DEPTH, 2, auxiliary FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive lost arbitrations before a forced drain (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
pipe_wb_en  in  1  pipeline write-back request
pipe_rd  in  ADDR_W  pipeline destination register
pipe_data  in  DATA_W  pipeline write-back data
aux_valid  in  1  auxiliary result valid
aux_ready  out  1  FIFO can accept an auxiliary result
aux_rd  in  ADDR_W  auxiliary destination register
aux_data  in  DATA_W  auxiliary result data
rf_we  out  1  register-file write enable
rf_wa  out  ADDR_W  register-file write address
rf_wd  out  DATA_W  register-file write data
pipe_stall  out  1  freeze request to the pipeline (hold MEM/WB and earlier)
hz_rn  in  ADDR_W  register being queried for a pending write
hz_busy  out  1  hz_rn matches a valid FIFO entry

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset: FIFO count, read pointer and write pointer = 0; starve counter = 0; state = NORMAL. While rst = 1, rf_we = 0, aux_ready = 0, pipe_stall = 0 and hz_busy = 0. A reset during a forced drain discards all FIFO contents and returns to NORMAL.
- Push: when aux_valid && aux_ready, the entry is written at the write pointer on the clock edge.
- aux_ready = (count < DEPTH). It does not depend on a same-cycle pop, so a full FIFO refuses a push even while it pops.
- Pointers wrap modulo DEPTH. A simultaneous push and pop leaves count unchanged.
- No bypass: an auxiliary result reaches rf_we no earlier than the cycle after it is accepted (minimum latency 1).
- Write-port outputs are combinational from the current state and inputs. When rf_we = 0, rf_wa = 0 and rf_wd = 0.
- State NORMAL, grant rules:
  - pipe_wb_en = 1: pipeline granted (rf_we = 1, rf_wa = pipe_rd, rf_wd = pipe_data). If the FIFO is non-empty, the starve counter increments.
  - pipe_wb_en = 0 and FIFO non-empty: FIFO head popped and written. Starve counter cleared.
  - FIFO empty: starve counter cleared.
  - Next state is FORCE when the counter reaches STARVE_LIMIT on this edge.
- State FORCE (exactly one cycle):
  - pipe_stall = 1; FIFO head granted and popped; pipeline request ignored.
  - The pipeline re-presents its request next cycle because its registers are frozen.
  - Starve counter cleared; next state NORMAL.
- pipe_stall = 0 in NORMAL.
- hz_busy is combinational: OR over valid entries of (entry.rd == hz_rn). The entry being popped this cycle still counts as busy.
- Counter width: clog2(STARVE_LIMIT+1); it saturates and never wraps.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, arbiter state enum (NORMAL, FORCE), and the FIFO entry struct {rd, data}.
- Sub-module wb_aux_fifo: storage, pointers, count, full/empty, and per-entry valid/rd exposure for the hazard compare. Arbitration and the starve FSM stay in the top module.

Test Plan:
- Reset with aux_valid = 1 → rf_we = 0, aux_ready = 0, pipe_stall = 0; first cycle after release aux_ready = 1, count = 0.
- pipe_wb_en = 0; push aux {rd = 3, data = 0xDEADBEEF} → next cycle rf_we = 1, rf_wa = 3, rf_wd = 0xDEADBEEF; the following cycle rf_we = 0.
- Push 2 entries (rd = 1, rd = 2), pipe_wb_en held 1 → aux_ready = 0 after 2 pushes. Pipeline wins 4 cycles, then pipe_stall = 1 for one cycle with rf_wa = 1. Pipeline wins again; entry rd = 2 drains at the next forced drain or idle cycle.
- FIFO holding rd = 5, hz_rn = 5 → hz_busy = 1; hz_rn = 6 → 0; after the rd = 5 pop, hz_busy = 0 the next cycle.
- Full FIFO with pipe idle and aux_valid = 1 → pop occurs, no push that cycle; push accepted the next cycle; pointer wrap verified over 5 push/pop pairs with in-order data.
- Assert rst during FORCE → pipe_stall = 0 immediately, FIFO empty, hz_busy = 0, no rf_we until a new push.
